video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Video stream source that produces the 24-bit RGB pixel bus plus `dv`/`hs`/`vs` timing consumed by the luma conversion stage and the rest of the pixel pipeline. It runs horizontal and vertical counters for a parameterised raster and paints one of four test patterns into the active area. It is the transmitter end of the pipeline's video interface and serves as bring-up stimulus and as a built-in self-test source.

## Interface
- `H_ACTIVE`, 640: active pixels per line; must be a multiple of 8.
- `H_FP`, 16: horizontal front porch, in clocks.
- `H_SYNC`, 96: horizontal sync width, in clocks.
- `H_BP`, 48: horizontal back porch, in clocks.
- `V_ACTIVE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `clk` input 1: pixel clock. This is the only clock.
- `rst` input 1: asynchronous, active-low reset.
- `en` input 1: run request.
- `pattern_sel` input 2: 0 = colour bars, 1 = ramp, 2 = checker, 3 = solid.
- `solid_rgb_i` input 24: colour used by pattern 3, as {R,G,B}.
- `rgb_o` output 24: pixel value as {R[23:16], G[15:8], B[7:0]}.
- `dv_o` output 1: data valid (active area).
- `hs_o` output 1: horizontal sync, active high.
- `vs_o` output 1: vertical sync, active high.
- `frame_start_o` output 1: one-cycle pulse coincident with pixel (0,0).

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- FSM states are IDLE and RUN.
  - IDLE: `hcnt`=0, `vcnt`=0. When `en`=1, go to RUN.
  - RUN: `hcnt` increments each clock and wraps at H_TOTAL-1. On each wrap `vcnt` increments and wraps at V_TOTAL-1.
  - At the final pixel of a frame (`hcnt`=H_TOTAL-1, `vcnt`=V_TOTAL-1):
    - if `en`=0, go to IDLE;
    - otherwise continue with (0,0).
  - Dropping `en` mid-frame never truncates the current frame.
- Decode, evaluated from the counters:
  - dv = `hcnt`<H_ACTIVE and `vcnt`<V_ACTIVE.
  - hs = H_ACTIVE+H_FP ≤ `hcnt` < H_ACTIVE+H_FP+H_SYNC, in every line including vertical blanking.
  - vs = V_ACTIVE+V_FP ≤ `vcnt` < V_ACTIVE+V_FP+V_SYNC, for entire lines aligned to `hcnt`=0.
- Frame-boundary capture: `pattern_sel` and `solid_rgb_i` are captured when (`hcnt`,`vcnt`)=(0,0) in RUN, including on entry from IDLE. Changes mid-frame have no effect until the next frame.
- Patterns (applied only when dv=1; otherwise `rgb_o`=0):
  - 0, colour bars: 8 equal bars of width H_ACTIVE/8, in the order FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
    - Bar index comes from a bar-pixel counter and a 3-bit bar index, reset at `hcnt`=0. No divider.
  - 1, ramp: R=G=B=`hcnt`[7:0]; wraps every 256 pixels.
  - 2, checker: the pixel is FFFFFF if `hcnt`[5]^`vcnt`[5] is set, else 000000.
  - 3, solid: the captured `solid_rgb_i`.
- Counter widths: `hcnt` is $clog2(H_TOTAL) bits and `vcnt` is $clog2(V_TOTAL) bits. Counters never exceed TOTAL-1.

## Timing
- All outputs are registered and are 0 during reset. Reset asserted at any time, including mid-line, clears all outputs immediately (asynchronously) and forces IDLE with counters at 0.
- Latency from the counters to the outputs is one clock. Outputs for counter value (h,v) appear after the edge following the one at which the counters hold (h,v).
- Start-up: the edge that samples `en`=1 in IDLE enters RUN with the counters at (0,0). At the next edge `dv_o`=1 and `frame_start_o`=1.
- In IDLE, all outputs are 0.
- `frame_start_o` is high for exactly one clock per frame.
- `rgb_o`, `dv_o`, `hs_o` and `vs_o` are always mutually aligned in the same cycle.

## Test plan
Benches use H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1. This gives 24 clocks per line and 192 clocks per frame.

- Reset, then `en`=0 for 500 clocks -> all outputs stay 0 and `frame_start_o` never pulses.
- `en`=1, `pattern_sel`=0 -> `frame_start_o` and `dv_o` both rise 2 edges after `en` is first sampled high. `rgb_o` pairs follow per line: FFFFFF, FFFFFF, FFFF00, FFFF00 … 000000, 000000. `dv_o` is high for 16 clocks, `hs_o` is high for 3 clocks starting 18 clocks after each `dv_o` rise, and the period is 24.
- Vertical check -> per frame, 4 lines contain `dv_o` and `vs_o` is high for 48 consecutive clocks starting at the line-6 boundary (lines 5–6, zero-based). `frame_start_o` repeats every 192 clocks.
- `pattern_sel` changes 0 to 3 and `solid_rgb_i`=123456 at line 2 -> the current frame stays colour bars, and the next frame shows every active pixel as 123456.
- `pattern_sel`=1 and `pattern_sel`=2 -> the ramp outputs pixel n = {n,n,n} for n=0..15. The checker outputs all 000000 in the active area, since `hcnt`[5] and `vcnt`[5] are both 0.
- `en` dropped at line 1 -> the frame completes its full 192 clocks, then all outputs are 0. Reset pulsed mid-line during a later run -> outputs clear without waiting for a clock edge, and the next run restarts at (0,0).

Source files
------------

// File: rtl/video_pattern_gen.sv
// Raster timing generator and test-pattern source: counts pixels and lines for
// a parameterised frame and paints bars, ramp, checker or a solid colour.
module video_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb_i,
    output logic [23:0] rgb_o,
    output logic        dv_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic        frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [BW-1:0] bar_px;
    logic [2:0]    bar_idx;
    logic [1:0]    sel_q;
    logic [23:0]   solid_q;

    logic          h_last, v_last, frame0, dv, hs, vs, chk;
    logic [1:0]    sel_eff;
    logic [23:0]   solid_eff, bar_rgb, pix;

    always_comb begin
        h_last    = (hcnt == H_LAST);
        v_last    = (vcnt == V_LAST);
        frame0    = (hcnt == '0) && (vcnt == '0);
        // Pixel (0,0) already uses the freshly captured selection.
        sel_eff   = frame0 ? pattern_sel : sel_q;
        solid_eff = frame0 ? solid_rgb_i : solid_q;
        dv = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
        hs = (int'(hcnt) >= H_ACTIVE + H_FP) && (int'(hcnt) < H_ACTIVE + H_FP + H_SYNC);
        vs = (int'(vcnt) >= V_ACTIVE + V_FP) && (int'(vcnt) < V_ACTIVE + V_FP + V_SYNC);
        chk = 1'(hcnt >> 5) ^ 1'(vcnt >> 5);

        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            3'd7: bar_rgb = 24'h000000;
            default: bar_rgb = 24'h000000;
        endcase

        pix = 24'h000000;
        case (sel_eff)
            2'd0: pix = bar_rgb;
            2'd1: pix = {3{8'(hcnt)}};
            2'd2: pix = chk ? 24'hFFFFFF : 24'h000000;
            2'd3: pix = solid_eff;
            default: pix = 24'h000000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            hcnt          <= '0;
            vcnt          <= '0;
            bar_px        <= '0;
            bar_idx       <= '0;
            sel_q         <= '0;
            solid_q       <= '0;
            rgb_o         <= '0;
            dv_o          <= 1'b0;
            hs_o          <= 1'b0;
            vs_o          <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hcnt          <= '0;
                    vcnt          <= '0;
                    bar_px        <= '0;
                    bar_idx       <= '0;
                    rgb_o         <= '0;
                    dv_o          <= 1'b0;
                    hs_o          <= 1'b0;
                    vs_o          <= 1'b0;
                    frame_start_o <= 1'b0;
                    if (en) state <= RUN;
                end
                RUN: begin
                    rgb_o         <= dv ? pix : '0;
                    dv_o          <= dv;
                    hs_o          <= hs;
                    vs_o          <= vs;
                    frame_start_o <= frame0;
                    if (frame0) begin
                        sel_q   <= pattern_sel;
                        solid_q <= solid_rgb_i;
                    end
                    if (h_last) begin
                        hcnt    <= '0;
                        bar_px  <= '0;
                        bar_idx <= '0;
                        vcnt    <= v_last ? '0 : vcnt + VW'(1);
                        // Leaving RUN only at the last pixel keeps frames whole.
                        if (v_last && !en) state <= IDLE;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                        if (bar_px == BAR_LAST) begin
                            bar_px  <= '0;
                            bar_idx <= bar_idx + 3'd1;
                        end else begin
                            bar_px <= bar_px + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: frame-position reference model checked every
// cycle, plus literal pins for timing, bars, ramp, checker and reset.
module tb_video_pattern_gen;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;

    logic        clk, rst, en;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb_i;
    logic [23:0] rgb_o;
    logic        dv_o, hs_o, vs_o, frame_start_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pattern_sel(pattern_sel), .solid_rgb_i(solid_rgb_i),
        .rgb_o(rgb_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
        .frame_start_o(frame_start_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_col(input int k);
        case (k)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] ref_pix(input int h, input int v, input int sel,
                                            input logic [23:0] solid);
        if (!(h < HA && v < VA)) return 24'h0;
        case (sel)
            0: return bar_col(h / (HA / 8));
            1: return {3{8'(h)}};
            2: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            default: return solid;
        endcase
    endfunction

    // Reference: a single frame position index, outputs derived from it.
    bit          m_run;
    int          m_pos, m_sel;
    logic [23:0] m_solid;
    logic [23:0] e_rgb = '0;
    logic        e_dv = 0, e_hs = 0, e_vs = 0, e_fs = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run <= 0; m_pos <= 0; m_sel <= 0; m_solid <= '0;
            e_rgb <= '0; e_dv <= 0; e_hs <= 0; e_vs <= 0; e_fs <= 0;
        end else if (!m_run) begin
            e_rgb <= '0; e_dv <= 0; e_hs <= 0; e_vs <= 0; e_fs <= 0;
            if (en) begin m_run <= 1; m_pos <= 0; end
        end else begin
            e_rgb <= ref_pix(m_pos % HT, m_pos / HT,
                             (m_pos == 0) ? int'(pattern_sel) : m_sel,
                             (m_pos == 0) ? solid_rgb_i : m_solid);
            e_dv  <= (m_pos % HT) < HA && (m_pos / HT) < VA;
            e_hs  <= (m_pos % HT) >= HA + HFP && (m_pos % HT) < HA + HFP + HSY;
            e_vs  <= (m_pos / HT) >= VA + VFP && (m_pos / HT) < VA + VFP + VSY;
            e_fs  <= (m_pos == 0);
            if (m_pos == 0) begin m_sel <= int'(pattern_sel); m_solid <= solid_rgb_i; end
            if (m_pos == FT - 1 && !en) begin m_run <= 0; m_pos <= 0; end
            else m_pos <= (m_pos + 1) % FT;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("rgb", rgb_o, e_rgb);
            check("dv", dv_o, e_dv);
            check("hs", hs_o, e_hs);
            check("vs", vs_o, e_vs);
            check("frame_start", frame_start_o, e_fs);
        end
    end

    // Returns the number of falling edges until frame_start_o is seen, -1 on timeout.
    task automatic wait_fs(output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (frame_start_o) begin n = i; break; end
        end
    endtask

    logic [23:0] rec_rgb [FT];
    logic        rec_dv [FT], rec_hs [FT], rec_vs [FT];

    initial begin
        int n, cnt_dv, cnt_fs, cnt_hs, cnt_vs, first_hs, first_vs, last_vs;
        rst = 1; en = 0; pattern_sel = 0; solid_rgb_i = '0;
        #2 rst = 0;
        repeat (3) @(negedge clk);
        check("reset_rgb", rgb_o, 24'h0);
        check("reset_dv", {dv_o, hs_o, vs_o, frame_start_o}, 4'b0000);
        rst = 1;
        chk_on = 1;

        // Idle with en low
        cnt_dv = 0; cnt_fs = 0;
        repeat (500) begin
            @(negedge clk);
            cnt_dv += int'(dv_o | hs_o | vs_o | (rgb_o != 0));
            cnt_fs += int'(frame_start_o);
        end
        check("idle_activity", cnt_dv, 0);
        check("idle_fs", cnt_fs, 0);

        // Start-up and first frame of colour bars
        en = 1; pattern_sel = 0;
        wait_fs(n);
        check("start_latency", n, 2);
        check("start_dv", dv_o, 1);
        rec_rgb[0] = rgb_o; rec_dv[0] = dv_o; rec_hs[0] = hs_o; rec_vs[0] = vs_o;
        for (int i = 1; i < FT; i++) begin
            @(negedge clk);
            rec_rgb[i] = rgb_o; rec_dv[i] = dv_o; rec_hs[i] = hs_o; rec_vs[i] = vs_o;
        end
        cnt_dv = 0; cnt_hs = 0; cnt_vs = 0; first_hs = -1; first_vs = -1; last_vs = -1;
        for (int i = 0; i < FT; i++) begin
            cnt_dv += int'(rec_dv[i]);
            cnt_hs += int'(rec_hs[i]);
            cnt_vs += int'(rec_vs[i]);
            if (rec_hs[i] && first_hs < 0) first_hs = i;
            if (rec_vs[i] && first_vs < 0) first_vs = i;
            if (rec_vs[i]) last_vs = i;
        end
        check("dv_per_frame", cnt_dv, 64);
        check("hs_per_frame", cnt_hs, 24);
        check("hs_offset", first_hs, 18);
        check("vs_count", cnt_vs, 48);
        check("vs_first", first_vs, 120);
        check("vs_last", last_vs, 167);
        for (int k = 0; k < 8; k++) begin
            check("bar_even", rec_rgb[2*k], bar_col(k));
            check("bar_odd", rec_rgb[2*k+1], bar_col(k));
        end
        @(negedge clk);
        check("fs_period", frame_start_o, 1);

        // Mid-frame switch to solid: takes effect at the next frame only
        repeat (2 * HT) @(negedge clk);
        pattern_sel = 3; solid_rgb_i = 24'h123456;
        check("bars_hold", rgb_o, 24'hFFFFFF);
        wait_fs(n);
        check("fs_after_switch", n, FT - 2 * HT);
        check("solid_pix", rgb_o, 24'h123456);

        // Ramp frame
        pattern_sel = 1;
        wait_fs(n);
        for (int i = 0; i < HA; i++) begin
            check("ramp", rgb_o, {3{8'(i)}});
            @(negedge clk);
        end

        // Checker frame
        pattern_sel = 2;
        wait_fs(n);
        for (int i = 0; i < HA; i++) begin
            check("checker", rgb_o, 24'h0);
            @(negedge clk);
        end

        // Drop en at line 1: frame completes, then idle
        pattern_sel = 0;
        wait_fs(n);
        repeat (HT) @(negedge clk);
        en = 0;
        cnt_dv = 0; cnt_fs = 0;
        repeat (300) begin
            @(negedge clk);
            cnt_dv += int'(dv_o);
            cnt_fs += int'(frame_start_o);
        end
        check("drop_dv_tail", cnt_dv, 47);
        check("drop_fs", cnt_fs, 0);
        check("drop_idle", {rgb_o, dv_o, hs_o, vs_o}, 27'h0);

        // Randomized run
        en = 1;
        repeat (2500) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) solid_rgb_i = 24'($urandom);
            if ($urandom_range(0, 299) == 0) en = ~en;
        end

        // Asynchronous reset mid-line
        en = 1;
        wait_fs(n);
        if (n < 0) wait_fs(n);
        check("fs_before_reset", n > 0, 1);
        repeat (5) @(negedge clk);
        check("pre_reset_dv", dv_o, 1);
        @(posedge clk);
        #3 rst = 0;
        #1;
        check("async_clr_dv", dv_o, 0);
        check("async_clr_rgb", rgb_o, 24'h0);
        @(negedge clk);
        rst = 1;
        wait_fs(n);
        check("restart_latency", n, 2);
        repeat (50) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
